// File: rtl/vram_pkg.sv
// vram_pkg
//   Shared definitions for the VRAM controller slice: the memory-side FSM
//   state type, default frame/sprite-sheet geometry, the RGB332 transparent
//   colour, the write-buffer entry width and the pixel byte-address helper.
package vram_pkg;

  typedef enum logic [1:0] {
    READ,
    WR_SETUP,
    WR_PULSE
  } vram_state_t;

  localparam int unsigned DEF_BG_WIDTH    = 640;
  localparam int unsigned DEF_BG_HEIGHT   = 480;
  localparam int unsigned DEF_SPRITE_BASE = 307200;
  localparam int unsigned DEF_SHEET_WIDTH = 512;
  localparam int unsigned DEF_FIFO_DEPTH  = 16;

  localparam logic [7:0]  RGB332_TRANSPARENT = 8'hE3;

  // Write buffer entry: {byte address[19:0], data[7:0]}
  localparam int unsigned WR_ENTRY_W = 28;

  // base + y*pitch + x, computed at 20 bits and wrapping modulo 2^20.
  function automatic logic [19:0] pixel_byte_addr(input logic [19:0] base,
                                                   input logic [19:0] pitch,
                                                   input logic [9:0]  x,
                                                   input logic [9:0]  y);
    return base + (pitch * {10'b0, y}) + {10'b0, x};
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo
//   Synchronous write buffer for CPU/loader byte writes.
//   Ports:
//     clk, reset_n        clock, synchronous active-low reset
//     push, push_data     enqueue one entry (ignored while full)
//     pop                 dequeue the head entry (ignored while empty)
//     head                current head entry
//     full, empty         status flags (full is registered)
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned WIDTH = WR_ENTRY_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign head    = mem[rptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // full is registered from the next count, so a pop cannot free a slot
  // for the producer in the same cycle, and it is held high during reset
  // to refuse pushes until the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/vram_controller.sv
// vram_controller
//   Memory-side responder for the GPU VRAM read interface. Streams one
//   background/sprite pixel read per cycle from a 16-bit SRAM (2-edge
//   latency) and drains buffered byte writes while the VGA write window
//   is open.
//   Ports:
//     Clk, Reset_n                     memory clock, sync active-low reset
//     VRAM_READ_SPRITE, VRAM_X/Y       read request (region select, coords)
//     VRAM_RGB                         returned RGB332 pixel
//     VRAM_WR_WINDOW                   SRAM writes permitted while high
//     WR_VALID/WR_READY/WR_ADDR/WR_DATA  buffered byte-write port
//     SRAM_*                           external SRAM address, data, strobes
module vram_controller
  import vram_pkg::*;
#(
  parameter int unsigned BG_WIDTH          = DEF_BG_WIDTH,
  parameter int unsigned BG_HEIGHT         = DEF_BG_HEIGHT,
  parameter int unsigned SPRITE_BASE       = DEF_SPRITE_BASE,
  parameter int unsigned SHEET_WIDTH       = DEF_SHEET_WIDTH,
  parameter logic [7:0]  TRANSPARENT_COLOR = RGB332_TRANSPARENT,
  parameter int unsigned FIFO_DEPTH        = DEF_FIFO_DEPTH
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        VRAM_READ_SPRITE,
  input  logic [9:0]  VRAM_X,
  input  logic [9:0]  VRAM_Y,
  output logic [7:0]  VRAM_RGB,
  input  logic        VRAM_WR_WINDOW,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [19:0] WR_ADDR,
  input  logic [7:0]  WR_DATA,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  input  logic [15:0] SRAM_DQ_IN,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  vram_state_t           state;

  logic [WR_ENTRY_W-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [19:0]           head_addr;
  logic [7:0]            head_data;
  logic                  start_write;

  logic [19:0]           rd_byte_addr;
  logic                  rd_oob;
  logic [7:0]            rd_fill;

  // Second read-pipeline stage: what to do with SRAM_DQ_IN at the next edge.
  logic                  rd_valid;
  logic                  rd_hi;
  logic                  rd_force;
  logic [7:0]            rd_force_val;

  assign WR_READY  = !fifo_full;
  assign fifo_push = WR_VALID && WR_READY;
  assign {head_addr, head_data} = fifo_head;

  // A new write may start from READ or straight out of WR_PULSE; WR_SETUP
  // always completes its pulse, so a window drop never truncates a write.
  assign start_write = !fifo_empty && VRAM_WR_WINDOW && (state != WR_SETUP);
  assign fifo_pop    = start_write;

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WR_ENTRY_W)
  ) u_wr_fifo (
    .clk       (Clk),
    .reset_n   (Reset_n),
    .push      (fifo_push),
    .push_data ({WR_ADDR, WR_DATA}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    rd_byte_addr = '0;
    rd_oob       = 1'b0;
    rd_fill      = '0;
    if (VRAM_READ_SPRITE) begin
      rd_byte_addr = pixel_byte_addr(20'(SPRITE_BASE), 20'(SHEET_WIDTH),
                                     VRAM_X, VRAM_Y);
      // Mirrored sprite coordinates that went negative wrap to large X.
      rd_oob       = (32'(VRAM_X) >= SHEET_WIDTH);
      rd_fill      = TRANSPARENT_COLOR;
    end else begin
      rd_byte_addr = pixel_byte_addr('0, 20'(BG_WIDTH), VRAM_X, VRAM_Y);
      rd_oob       = (32'(VRAM_X) >= BG_WIDTH) || (32'(VRAM_Y) >= BG_HEIGHT);
      rd_fill      = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= READ;
      VRAM_RGB     <= '0;
      SRAM_ADDR    <= '0;
      SRAM_DQ_OUT  <= '0;
      SRAM_DQ_OE   <= 1'b0;
      SRAM_CE_N    <= 1'b1;
      SRAM_OE_N    <= 1'b1;
      SRAM_WE_N    <= 1'b1;
      SRAM_UB_N    <= 1'b1;
      SRAM_LB_N    <= 1'b1;
      rd_valid     <= 1'b0;
      rd_hi        <= 1'b0;
      rd_force     <= 1'b0;
      rd_force_val <= '0;
    end else begin
      // Retire the read issued on the previous edge; held during writes.
      if (rd_valid) begin
        if (rd_force)   VRAM_RGB <= rd_force_val;
        else if (rd_hi) VRAM_RGB <= SRAM_DQ_IN[15:8];
        else            VRAM_RGB <= SRAM_DQ_IN[7:0];
      end

      case (state)
        WR_SETUP: begin
          state     <= WR_PULSE;
          SRAM_WE_N <= 1'b0;
          rd_valid  <= 1'b0;
        end

        default: begin
          if (start_write) begin
            state       <= WR_SETUP;
            SRAM_ADDR   <= {1'b0, head_addr[19:1]};
            SRAM_UB_N   <= ~head_addr[0];
            SRAM_LB_N   <= head_addr[0];
            SRAM_DQ_OUT <= {head_data, head_data};
            SRAM_DQ_OE  <= 1'b1;
            SRAM_CE_N   <= 1'b0;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            rd_valid    <= 1'b0;
          end else begin
            state        <= READ;
            SRAM_ADDR    <= {1'b0, rd_byte_addr[19:1]};
            SRAM_UB_N    <= ~rd_byte_addr[0];
            SRAM_LB_N    <= rd_byte_addr[0];
            SRAM_DQ_OE   <= 1'b0;
            SRAM_CE_N    <= 1'b0;
            SRAM_OE_N    <= 1'b0;
            SRAM_WE_N    <= 1'b1;
            rd_valid     <= 1'b1;
            rd_hi        <= rd_byte_addr[0];
            rd_force     <= rd_oob;
            rd_force_val <= rd_fill;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_controller.sv
// tb_vram_controller
//   Self-checking bench for vram_controller: a table of read vectors with
//   hand-computed addresses/strobes/pixels, plus directed sequences for the
//   write buffer, window drop and reset during a write pulse. A simple
//   16-bit SRAM model answers reads and applies byte-strobed writes.
module tb_vram_controller;

  logic        Clk;
  logic        Reset_n;
  logic        VRAM_READ_SPRITE;
  logic [9:0]  VRAM_X;
  logic [9:0]  VRAM_Y;
  logic [7:0]  VRAM_RGB;
  logic        VRAM_WR_WINDOW;
  logic        WR_VALID;
  logic        WR_READY;
  logic [19:0] WR_ADDR;
  logic [7:0]  WR_DATA;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_OUT;
  logic [15:0] SRAM_DQ_IN;
  logic        SRAM_DQ_OE;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;

  int n_checks = 0;
  int n_fail   = 0;

  vram_controller #(
    .BG_WIDTH          (640),
    .BG_HEIGHT         (480),
    .SPRITE_BASE       (307200),
    .SHEET_WIDTH       (512),
    .TRANSPARENT_COLOR (8'hE3),
    .FIFO_DEPTH        (16)
  ) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .VRAM_READ_SPRITE (VRAM_READ_SPRITE),
    .VRAM_X           (VRAM_X),
    .VRAM_Y           (VRAM_Y),
    .VRAM_RGB         (VRAM_RGB),
    .VRAM_WR_WINDOW   (VRAM_WR_WINDOW),
    .WR_VALID         (WR_VALID),
    .WR_READY         (WR_READY),
    .WR_ADDR          (WR_ADDR),
    .WR_DATA          (WR_DATA),
    .SRAM_ADDR        (SRAM_ADDR),
    .SRAM_DQ_OUT      (SRAM_DQ_OUT),
    .SRAM_DQ_IN       (SRAM_DQ_IN),
    .SRAM_DQ_OE       (SRAM_DQ_OE),
    .SRAM_CE_N        (SRAM_CE_N),
    .SRAM_OE_N        (SRAM_OE_N),
    .SRAM_WE_N        (SRAM_WE_N),
    .SRAM_UB_N        (SRAM_UB_N),
    .SRAM_LB_N        (SRAM_LB_N)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model with a backdoor preload port used while the DUT is in reset.
  logic [15:0] sram [0:(1<<20)-1];
  logic        pre_we;
  logic [19:0] pre_addr;
  logic [15:0] pre_data;

  assign SRAM_DQ_IN = sram[SRAM_ADDR];

  always @(posedge Clk) begin
    if (pre_we) begin
      sram[pre_addr] <= pre_data;
    end else if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_LB_N) sram[SRAM_ADDR][7:0]  <= SRAM_DQ_OUT[7:0];
      if (!SRAM_UB_N) sram[SRAM_ADDR][15:8] <= SRAM_DQ_OUT[15:8];
    end
  end

  typedef struct {
    logic        sel;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] word;
    logic [19:0] exp_addr;
    logic        exp_ub_n;
    logic        exp_lb_n;
    logic [7:0]  exp_rgb;
  } rd_vec_t;

  rd_vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [19:0] a, input logic [15:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic push_write(input logic [19:0] a, input logic [7:0] d);
    WR_VALID = 1'b1;
    WR_ADDR  = a;
    WR_DATA  = d;
    tick();
    WR_VALID = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int last_pulse;

    vecs[0]  = '{1'b0, 10'd3,    10'd2,    16'hAB12, 20'd641,    1'b0, 1'b1, 8'hAB};
    vecs[1]  = '{1'b1, 10'd4,    10'd1,    16'h55C3, 20'd153858, 1'b1, 1'b0, 8'hC3};
    vecs[2]  = '{1'b0, 10'd700,  10'd0,    16'h1234, 20'd350,    1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 10'd1020, 10'd0,    16'h9876, 20'd154110, 1'b1, 1'b0, 8'hE3};
    vecs[4]  = '{1'b0, 10'd0,    10'd0,    16'h00A5, 20'd0,      1'b1, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 10'd639,  10'd479,  16'h7E00, 20'd153599, 1'b0, 1'b1, 8'h7E};
    vecs[6]  = '{1'b0, 10'd5,    10'd480,  16'h4455, 20'd153602, 1'b0, 1'b1, 8'h00};
    vecs[7]  = '{1'b1, 10'd511,  10'd0,    16'h3C00, 20'd153855, 1'b0, 1'b1, 8'h3C};
    vecs[8]  = '{1'b1, 10'd512,  10'd0,    16'h0011, 20'd153856, 1'b1, 1'b0, 8'hE3};
    vecs[9]  = '{1'b1, 10'd7,    10'd1023, 16'hA100, 20'd415491, 1'b0, 1'b1, 8'hA1};
    vecs[10] = '{1'b0, 10'd640,  10'd0,    16'h0066, 20'd320,    1'b1, 1'b0, 8'h00};

    Reset_n          = 1'b0;
    VRAM_READ_SPRITE = 1'b0;
    VRAM_X           = '0;
    VRAM_Y           = '0;
    VRAM_WR_WINDOW   = 1'b0;
    WR_VALID         = 1'b0;
    WR_ADDR          = '0;
    WR_DATA          = '0;
    pre_we           = 1'b0;
    pre_addr         = '0;
    pre_data         = '0;

    // Reset held while the memory model is preloaded (well over 3 cycles).
    for (int i = 0; i < 11; i++) preload(vecs[i].exp_addr, vecs[i].word);
    for (int i = 0; i < 8; i++)  preload(20'h00800 + 20'(i), 16'hFFFF);
    preload(20'h01000, 16'hC0DE);
    preload(20'h01800, 16'h1111);
    preload(20'h02001, 16'h2222);

    check("rst_ce_n",   SRAM_CE_N,   1);
    check("rst_oe_n",   SRAM_OE_N,   1);
    check("rst_we_n",   SRAM_WE_N,   1);
    check("rst_ub_lb",  {SRAM_UB_N, SRAM_LB_N}, 2'b11);
    check("rst_rgb",    VRAM_RGB,    0);
    check("rst_ready",  WR_READY,    0);
    check("rst_addr",   SRAM_ADDR,   0);
    check("rst_dq_oe",  SRAM_DQ_OE,  0);
    check("rst_dq_out", SRAM_DQ_OUT, 0);

    Reset_n = 1'b1;
    tick();
    check("ready_after_reset", WR_READY, 1);

    // Table-driven single reads: addresses/strobes after edge k, pixel after k+1.
    for (int i = 0; i < 11; i++) begin
      VRAM_READ_SPRITE = vecs[i].sel;
      VRAM_X           = vecs[i].x;
      VRAM_Y           = vecs[i].y;
      tick();
      check($sformatf("v%0d_addr", i), SRAM_ADDR, vecs[i].exp_addr);
      check($sformatf("v%0d_ub_n", i), SRAM_UB_N, vecs[i].exp_ub_n);
      check($sformatf("v%0d_lb_n", i), SRAM_LB_N, vecs[i].exp_lb_n);
      check($sformatf("v%0d_rd_strobes", i),
            {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 4'b0010);
      tick();
      check($sformatf("v%0d_rgb", i), VRAM_RGB, vecs[i].exp_rgb);
    end

    // Back-to-back requests: result for request j-1 appears after edge j.
    for (int j = 0; j <= 5; j++) begin
      if (j < 5) begin
        VRAM_READ_SPRITE = vecs[j].sel;
        VRAM_X           = vecs[j].x;
        VRAM_Y           = vecs[j].y;
      end
      tick();
      if (j >= 1) check($sformatf("b2b%0d_rgb", j - 1), VRAM_RGB, vecs[j - 1].exp_rgb);
    end

    // Fill the buffer with the window closed.
    for (int i = 0; i < 16; i++) begin
      WR_VALID = 1'b1;
      WR_ADDR  = 20'h01000 + 20'(i);
      WR_DATA  = 8'h10 + 8'(i * 7);
      check($sformatf("fill%0d_ready", i), WR_READY, 1);
      tick();
    end
    WR_ADDR = 20'h02000;
    WR_DATA = 8'hEE;
    check("fill17_ready", WR_READY, 0);
    tick();
    WR_VALID = 1'b0;
    check("fill_no_write", SRAM_WE_N, 1);

    // Drain: 16 pulses at cycles 1,3,...,31 after opening the window.
    VRAM_WR_WINDOW = 1'b1;
    pulses     = 0;
    last_pulse = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 0) begin
        check("drain_setup_strobes",
              {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 4'b0111);
        check("drain_setup_addr", SRAM_ADDR, 20'h00800);
        check("drain_setup_ub_lb", {SRAM_UB_N, SRAM_LB_N}, 2'b10);
        check("drain_ready_after_pop", WR_READY, 1);
      end
      if (c == 1) check("drain_dq_out", SRAM_DQ_OUT, 16'h1010);
      if (!SRAM_WE_N) begin
        pulses++;
        last_pulse = c;
      end
    end
    check("drain_pulses", pulses, 16);
    check("drain_last_pulse", last_pulse, 31);
    check("drain_back_to_read", {SRAM_OE_N, SRAM_DQ_OE}, 2'b00);
    for (int i = 0; i < 16; i += 2) begin
      logic [7:0] lo;
      logic [7:0] hi;
      lo = 8'h10 + 8'(i * 7);
      hi = 8'h10 + 8'((i + 1) * 7);
      check($sformatf("mem_word%0d", i / 2), sram[20'h00800 + 20'(i / 2)], {hi, lo});
    end
    check("mem_rejected_write", sram[20'h01000], 16'hC0DE);
    VRAM_WR_WINDOW = 1'b0;
    tick();

    // Window drops during WR_SETUP: the pulse still happens.
    push_write(20'h03001, 8'h5A);
    VRAM_WR_WINDOW = 1'b1;
    tick();
    check("wd_setup", {SRAM_WE_N, SRAM_DQ_OE, SRAM_OE_N}, 3'b111);
    check("wd_setup_addr", SRAM_ADDR, 20'h01800);
    check("wd_setup_ub_lb", {SRAM_UB_N, SRAM_LB_N}, 2'b01);
    VRAM_WR_WINDOW = 1'b0;
    tick();
    check("wd_pulse", SRAM_WE_N, 0);
    tick();
    check("wd_read_resume", {SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE}, 3'b100);
    tick();
    check("wd_mem", sram[20'h01800], 16'h5A11);

    // Reset during WR_PULSE: WE_N released and the queued write discarded.
    push_write(20'h04000, 8'h77);
    push_write(20'h04002, 8'h88);
    VRAM_WR_WINDOW = 1'b1;
    tick();
    tick();
    check("rp_pulse", SRAM_WE_N, 0);
    Reset_n = 1'b0;
    tick();
    check("rp_we_n", SRAM_WE_N, 1);
    check("rp_ready", WR_READY, 0);
    check("rp_dq_oe", SRAM_DQ_OE, 0);
    Reset_n = 1'b1;
    tick();
    check("rp_ready_after", WR_READY, 1);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (!SRAM_WE_N) pulses++;
    end
    check("rp_fifo_empty", pulses, 0);
    check("rp_mem_untouched", sram[20'h02001], 16'h2222);
    VRAM_WR_WINDOW = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
